multiplier_seq_signed: RTL and testbench

Iterative, parametrised two's-complement multiplier with valid/ready handshakes on both sides. It is the area-lean successor to the single-cycle signed multiplier used in the FIR datapath. Differences from that multiplier:
- operand widths are independent;
- the output is true two's complement, not sign-magnitude;
- the output can be scaled by a fixed right shift;
- an overflow flag is reported.

It sits between a coefficient/sample source and an accumulator wherever throughput of one product per `B_WIDTH+2` cycles is sufficient.

---
 rtl/multiplier_seq_signed_if.sv | 38 +++
 rtl/multiplier_seq_signed.sv | 180 ++++++++++++++++++
 tb/tb_multiplier_seq_signed.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/multiplier_seq_signed_if.sv
// Handshake bundle for multiplier_seq_signed: operand channel (in_*) and result channel (out_*).
// The master drives operands and result acceptance; the slave is the multiplier.
interface multiplier_seq_signed_if #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [A_WIDTH-1:0]   a;
    logic [B_WIDTH-1:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] product;
    logic                 overflow;

    modport master (
        output in_valid,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output overflow
    );
endinterface

// File: rtl/multiplier_seq_signed.sv
// Iterative shift-and-add signed multiplier, one product per B_WIDTH+2 cycles, with scaling and overflow.
// Optional macro MULT_SAT_EN: saturate instead of wrap when the scaled product does not fit OUT_WIDTH.
module multiplier_seq_signed #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 32,
    parameter int SHIFT     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    multiplier_seq_signed_if.slave  bus
);
    localparam int P     = A_WIDTH + B_WIDTH;
    localparam int CNT_W = $clog2(B_WIDTH + 1);
    localparam int EXCESS = P - OUT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [A_WIDTH-1:0]   a_mag_reg;
    logic [B_WIDTH-1:0]   b_mag_reg;
    logic                 sign_reg;
    logic [P-1:0]         acc_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [OUT_WIDTH-1:0] product_reg;
    logic                 overflow_reg;

    logic                 in_ready_c;
    logic                 accept;
    logic                 last_iter;
    logic [A_WIDTH-1:0]   a_abs;
    logic [B_WIDTH-1:0]   b_abs;
    logic [P-1:0]         addend;
    logic [P-1:0]         signed_acc;
    logic signed [P-1:0]  shifted;
    logic [EXCESS:0]      excess_diff;
    logic                 fits;
    logic [OUT_WIDTH-1:0] narrow_val;
    logic                 narrow_ovf;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    assign last_iter = (cnt_reg == CNT_W'(B_WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        in_ready_c = 1'b0;
        case (state_reg)
            S_IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (last_iter) begin
                    state_next = S_FIX;
                end
            end
            S_FIX: begin
                state_next = S_DONE;
            end
            S_DONE: begin
                // Releasing the result opens the operand port in the same cycle.
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = bus.in_valid ? S_CALC : S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign accept        = bus.in_valid && in_ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.product   = product_reg;
    assign bus.overflow  = overflow_reg;

    // ------------------------------------------------------------------
    // Operand conditioning: magnitudes are unsigned so the most negative
    // operand value has a representable magnitude.
    // ------------------------------------------------------------------
    always_comb begin
        a_abs = bus.a;
        b_abs = bus.b;
        if (bus.a[A_WIDTH-1]) begin
            a_abs = ~bus.a + A_WIDTH'(1);
        end
        if (bus.b[B_WIDTH-1]) begin
            b_abs = ~bus.b + B_WIDTH'(1);
        end
    end

    assign addend = P'(a_mag_reg) << cnt_reg;

    // ------------------------------------------------------------------
    // Sign restore, scaling and narrowing
    // ------------------------------------------------------------------
    assign signed_acc = sign_reg ? (~acc_reg + P'(1)) : acc_reg;
    assign shifted    = $signed(signed_acc) >>> SHIFT;

    // The value fits when every bit above the output MSB replicates it.
    genvar gi;
    generate
        for (gi = 0; gi <= EXCESS; gi++) begin : g_excess
            assign excess_diff[gi] = shifted[OUT_WIDTH-1+gi] ^ shifted[OUT_WIDTH-1];
        end
    endgenerate

    assign fits = ~|excess_diff;

    always_comb begin
        narrow_val = shifted[OUT_WIDTH-1:0];
        narrow_ovf = ~fits;
`ifdef MULT_SAT_EN
        if (!fits) begin
            narrow_val = shifted[P-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_mag_reg    <= '0;
            b_mag_reg    <= '0;
            sign_reg     <= 1'b0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            product_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_CALC: begin
                    if (b_mag_reg[0]) begin
                        acc_reg <= acc_reg + addend;
                    end
                    b_mag_reg <= b_mag_reg >> 1;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                end
                S_FIX: begin
                    product_reg  <= narrow_val;
                    overflow_reg <= narrow_ovf;
                end
                default: begin
                end
            endcase
            // Accept only happens in IDLE or DONE, never alongside a CALC update.
            if (accept) begin
                a_mag_reg <= a_abs;
                b_mag_reg <= b_abs;
                sign_reg  <= bus.a[A_WIDTH-1] ^ bus.b[B_WIDTH-1];
                acc_reg   <= '0;
                cnt_reg   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_multiplier_seq_signed.sv
// Directed bench for multiplier_seq_signed: three instances (8/8/16, 8/8/8, 8/8/8 with SHIFT=7)
// sharing one clock and reset; expected values are hand-computed constants.
module tb_multiplier_seq_signed;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    multiplier_seq_signed_if #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(16)) if0 ();
    multiplier_seq_signed_if #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8))  if1 ();
    multiplier_seq_signed_if #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8))  if2 ();

    multiplier_seq_signed #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(16), .SHIFT(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );
    multiplier_seq_signed #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8), .SHIFT(0)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );
    multiplier_seq_signed #(.A_WIDTH(8), .B_WIDTH(8), .OUT_WIDTH(8), .SHIFT(7)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input bit iv, input int av, input int bv, input bit ordy);
        case (sel)
            0: begin if0.in_valid = iv; if0.a = 8'(av); if0.b = 8'(bv); if0.out_ready = ordy; end
            1: begin if1.in_valid = iv; if1.a = 8'(av); if1.b = 8'(bv); if1.out_ready = ordy; end
            default: begin if2.in_valid = iv; if2.a = 8'(av); if2.b = 8'(bv); if2.out_ready = ordy; end
        endcase
    endtask

    function automatic int rd_prod(input int sel);
        case (sel)
            0:       return int'($signed(if0.product));
            1:       return int'($signed(if1.product));
            default: return int'($signed(if2.product));
        endcase
    endfunction

    function automatic int rd_ovf(input int sel);
        case (sel)
            0:       return int'(if0.overflow);
            1:       return int'(if1.overflow);
            default: return int'(if2.overflow);
        endcase
    endfunction

    function automatic int rd_ovld(input int sel);
        case (sel)
            0:       return int'(if0.out_valid);
            1:       return int'(if1.out_valid);
            default: return int'(if2.out_valid);
        endcase
    endfunction

    function automatic int rd_irdy(input int sel);
        case (sel)
            0:       return int'(if0.in_ready);
            1:       return int'(if1.in_ready);
            default: return int'(if2.in_ready);
        endcase
    endfunction

    // Called just after the accept edge; expects out_valid after exactly 9 more edges.
    task automatic wait_result(input int sel, input string tag, input int exp_p, input int exp_o);
        int lat;
        bit busy_ready;
        lat = 0;
        busy_ready = 1'b0;
        while (rd_ovld(sel) == 0 && lat < 40) begin
            if (rd_irdy(sel) != 0) busy_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, 9);
        check({tag, ".in_ready_busy"}, int'(busy_ready), 0);
        check({tag, ".product"}, rd_prod(sel), exp_p);
        check({tag, ".overflow"}, rd_ovf(sel), exp_o);
        $display("txn %s: dut%0d product=%0d overflow=%0d latency=%0d", tag, sel, rd_prod(sel), rd_ovf(sel), lat);
    endtask

    task automatic release_result(input int sel, input string tag);
        drive(sel, 1'b0, 0, 0, 1'b1);
        @(posedge clk); #1;
        drive(sel, 1'b0, 0, 0, 1'b0);
        check({tag, ".out_valid_drop"}, rd_ovld(sel), 0);
    endtask

    // Starts and ends one cycle-phase after a rising edge with the DUT in IDLE.
    task automatic run_op(input int sel, input int av, input int bv, input int exp_p, input int exp_o,
                          input string tag);
        drive(sel, 1'b1, av, bv, 1'b0);
        #1;
        check({tag, ".in_ready"}, rd_irdy(sel), 1);
        @(posedge clk); #1;
        // Scrambled operands after accept must not affect the result.
        drive(sel, 1'b0, 8'hA5, 8'h5A, 1'b0);
        wait_result(sel, tag, exp_p, exp_o);
        release_result(sel, tag);
    endtask

    initial begin
        int stable_bad;
        int stale;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            check($sformatf("reset%0d.in_ready", s), rd_irdy(s), 1);
            check($sformatf("reset%0d.out_valid", s), rd_ovld(s), 0);
            check($sformatf("reset%0d.product", s), rd_prod(s), 0);
            check($sformatf("reset%0d.overflow", s), rd_ovf(s), 0);
        end
        @(posedge clk); #1;

        // Full-width and sign combinations, 8/8/16
        run_op(0, -128, -128, 16384, 0, "corner");
        run_op(0,   -7,    3,   -21, 0, "neg_pos");
        run_op(0,    7,   -3,   -21, 0, "pos_neg");
        run_op(0,    0, -128,     0, 0, "zero_neg");
        run_op(0,  127, -128, -16256, 0, "max_min");

        // Narrowing to 8 bits
`ifdef MULT_SAT_EN
        run_op(1,  100,    2,  127, 1, "nar_pos_ovf");
        run_op(1, -100,    2, -128, 1, "nar_neg_ovf");
        run_op(1,    8,   16,  127, 1, "nar_edge_ovf");
`else
        run_op(1,  100,    2,  -56, 1, "nar_pos_ovf");
        run_op(1, -100,    2,   56, 1, "nar_neg_ovf");
        run_op(1,    8,   16, -128, 1, "nar_edge_ovf");
`endif
        run_op(1,   -8,   16, -128, 0, "nar_edge_fit");
        run_op(1,    5,   -6,  -30, 0, "nar_fit");

        // Scaling by SHIFT=7
        run_op(2,   64,   64,   32, 0, "scl_pos");
        run_op(2,  -64,   64,  -32, 0, "scl_neg");
        run_op(2,   -1,    1,   -1, 0, "scl_floor");
        run_op(2,  127,  127,  126, 0, "scl_trunc");
`ifdef MULT_SAT_EN
        run_op(2, -128, -128,  127, 1, "scl_ovf");
`else
        run_op(2, -128, -128, -128, 1, "scl_ovf");
`endif

        // Back-pressure, then back-to-back accept through DONE
        drive(0, 1'b1, 5, -9, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0, 1'b0);
        wait_result(0, "bp_first", -45, 0);
        stable_bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rd_ovld(0) != 1 || rd_prod(0) != -45) stable_bad++;
        end
        check("bp_hold", stable_bad, 0);
        drive(0, 1'b1, -3, -11, 1'b1);
        #1;
        check("b2b.in_ready", rd_irdy(0), 1);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0, 1'b0);
        wait_result(0, "b2b_second", 33, 0);
        release_result(0, "b2b_second");

        // Reset in the 4th CALC cycle, together with in_valid and out_ready
        drive(0, 1'b1, 10, 10, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 0, 0, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(0, 1'b1, 3, 3, 1'b1);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 0, 0, 1'b0);
        #1;
        check("rst_mid.out_valid", rd_ovld(0), 0);
        check("rst_mid.product", rd_prod(0), 0);
        check("rst_mid.in_ready", rd_irdy(0), 1);
        stale = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (rd_ovld(0) != 0) stale++;
        end
        check("rst_mid.no_stale", stale, 0);
        $display("txn rst_mid: dut0 out_valid pulses after reset=%0d", stale);

        run_op(0, -2, 50, -100, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
